// File: rtl/bus_loader_pkg.sv
// Shared constants for the UART-to-membus loader: FSM encodings and protocol bytes.
package bus_loader_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_A_HI     = 4'd1;
    localparam state_t ST_A_LO     = 4'd2;
    localparam state_t ST_CNT      = 4'd3;
    localparam state_t ST_D_LO     = 4'd4;
    localparam state_t ST_D_HI     = 4'd5;
    localparam state_t ST_WR       = 4'd6;
    localparam state_t ST_RD_ISSUE = 4'd7;
    localparam state_t ST_RD_WAIT  = 4'd8;
    localparam state_t ST_TX_LO    = 4'd9;
    localparam state_t ST_TX_HI    = 4'd10;
    localparam state_t ST_ACK      = 4'd11;
    localparam state_t ST_CSUM     = 4'd12;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;

endpackage

// File: rtl/bus_loader.sv
// Byte-stream membus master: parses W/R frames from the UART, writes or reads membus words
// and returns read data / acknowledge bytes on the tx side.
// Optional feature: define BUS_LOADER_CHECKSUM_EN to require a trailing XOR byte on W frames.
module bus_loader
    import bus_loader_pkg::*;
#(
    parameter int unsigned width          = 16,
    parameter int unsigned addr_width     = 9,
    parameter int unsigned timeout_cycles = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  bus_req,
    input  logic                  bus_gnt,
    output logic [width-1:0]      data_write,
    input  logic [width-1:0]      data_read,
    output logic [addr_width-1:0] addr,
    output logic                  w_strobe,
    output logic                  err
);

    localparam int unsigned TmoW = $clog2(timeout_cycles + 1);

    state_t                state_q, state_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [width-1:0]      wdata_q, wdata_d;
    logic [width-1:0]      rdata_q, rdata_d;
    logic [8:0]            cnt_q, cnt_d;     // words remaining, 256 representable
    logic                  is_wr_q, is_wr_d;
    logic [7:0]            skid_q, skid_d;
    logic                  skid_vld_q, skid_vld_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;
    logic [7:0]            resp_q, resp_d;
    logic                  err_q, err_d;
`ifdef BUS_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    // Frame bytes come from the skid first so a byte caught during WR is never reordered.
    logic       in_vld;
    logic [7:0] in_byte;
    logic       take;
    logic       wait_st;

    // Next-state logic: frame parser, bus sequencing, skid and inter-byte timeout.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        is_wr_d    = is_wr_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        tmo_d      = tmo_q;
        resp_d     = resp_q;
        err_d      = 1'b0;
`ifdef BUS_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        in_vld  = skid_vld_q | rx_valid;
        in_byte = skid_vld_q ? skid_q : rx_data;
        take    = 1'b0;
        wait_st = 1'b0;

        case (state_q)
            ST_IDLE: begin
                skid_vld_d = 1'b0;
                resp_d     = ACK;
                if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                    is_wr_d = (rx_data == CMD_WRITE);
                    state_d = ST_A_HI;
`ifdef BUS_LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            ST_A_HI: begin
                wait_st = 1'b1;
                if (in_vld) begin
                    take    = 1'b1;
                    addr_d  = addr_width'({in_byte[0], 8'h00});
                    state_d = ST_A_LO;
                end
            end
            ST_A_LO: begin
                wait_st = 1'b1;
                if (in_vld) begin
                    take        = 1'b1;
                    addr_d[7:0] = in_byte;
                    state_d     = ST_CNT;
                end
            end
            ST_CNT: begin
                wait_st = 1'b1;
                if (in_vld) begin
                    take    = 1'b1;
                    cnt_d   = {(in_byte == 8'h00), in_byte};
                    state_d = is_wr_q ? ST_D_LO : ST_RD_ISSUE;
                end
            end
            ST_D_LO: begin
                wait_st = 1'b1;
                if (in_vld) begin
                    take         = 1'b1;
                    wdata_d[7:0] = in_byte;
                    state_d      = ST_D_HI;
                end
            end
            ST_D_HI: begin
                wait_st = 1'b1;
                if (in_vld) begin
                    take          = 1'b1;
                    wdata_d[15:8] = in_byte;
                    state_d       = ST_WR;
                end
            end
            ST_WR: begin
                if (rx_valid) begin
                    if (skid_vld_q) begin
                        err_d = 1'b1;
                    end else begin
                        skid_d     = rx_data;
                        skid_vld_d = 1'b1;
                    end
                end
                if (bus_gnt) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 9'd1;
`ifdef BUS_LOADER_CHECKSUM_EN
                    state_d = (cnt_q == 9'd1) ? ST_CSUM : ST_D_LO;
`else
                    state_d = (cnt_q == 9'd1) ? ST_ACK : ST_D_LO;
`endif
                end
            end
`ifdef BUS_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                wait_st = 1'b1;
                if (in_vld) begin
                    take    = 1'b1;
                    resp_d  = (in_byte == csum_q) ? ACK : NAK;
                    err_d   = (in_byte != csum_q);
                    state_d = ST_ACK;
                end
            end
`endif
            ST_RD_ISSUE: begin
                if (bus_gnt) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                rdata_d = data_read;
                addr_d  = addr_q + 1'b1;
                state_d = ST_TX_LO;
            end
            ST_TX_LO: begin
                if (tx_ready) state_d = ST_TX_HI;
            end
            ST_TX_HI: begin
                if (tx_ready) begin
                    cnt_d   = cnt_q - 9'd1;
                    state_d = (cnt_q == 9'd1) ? ST_IDLE : ST_RD_ISSUE;
                end
            end
            ST_ACK: begin
                skid_vld_d = 1'b0;
                if (tx_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A consumed skid byte is replaced by a byte arriving in the same cycle.
        if (take && skid_vld_q) begin
            skid_vld_d = rx_valid;
            if (rx_valid) skid_d = rx_data;
        end

`ifdef BUS_LOADER_CHECKSUM_EN
        if (take && state_q != ST_CSUM) csum_d = csum_q ^ in_byte;
`endif

        if (wait_st && !in_vld) begin
            if (tmo_q == TmoW'(timeout_cycles - 1)) begin
                tmo_d      = '0;
                err_d      = 1'b1;
                skid_vld_d = 1'b0;
                state_d    = ST_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            is_wr_q    <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            tmo_q      <= '0;
            resp_q     <= ACK;
            err_q      <= 1'b0;
`ifdef BUS_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            is_wr_q    <= is_wr_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            tmo_q      <= tmo_d;
            resp_q     <= resp_d;
            err_q      <= err_d;
`ifdef BUS_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Outputs decoded from registered state; strobe is gated by the live grant.
    always_comb begin
        bus_req    = (state_q != ST_IDLE);
        w_strobe   = (state_q == ST_WR) && bus_gnt;
        addr       = addr_q;
        data_write = wdata_q;
        err        = err_q;
        tx_valid   = (state_q == ST_TX_LO) || (state_q == ST_TX_HI) || (state_q == ST_ACK);
        case (state_q)
            ST_TX_LO: tx_data = rdata_q[7:0];
            ST_TX_HI: tx_data = rdata_q[15:8];
            ST_ACK:   tx_data = resp_q;
            default:  tx_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_bus_loader.sv
// Directed self-checking bench for bus_loader with a 1-cycle-latency membus model.
module tb_bus_loader;
    import bus_loader_pkg::*;

    localparam int unsigned TMO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] data_write;
    logic [15:0] data_read;
    logic [8:0]  addr;
    logic        w_strobe;
    logic        err;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    logic [7:0] xs;

    logic [15:0] mem [512];
    logic        poke;
    logic [8:0]  poke_addr;
    logic [15:0] poke_data;

    logic [8:0]  wq_a [$];
    logic [15:0] wq_d [$];
    logic [7:0]  txq  [$];

    always #5 clk = ~clk;

    bus_loader #(
        .width(16),
        .addr_width(9),
        .timeout_cycles(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .bus_req(bus_req),
        .bus_gnt(bus_gnt),
        .data_write(data_write),
        .data_read(data_read),
        .addr(addr),
        .w_strobe(w_strobe),
        .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Membus model: registered read data, writes on strobe.
    always @(posedge clk) begin
        if (poke) mem[poke_addr] <= poke_data;
        else if (w_strobe) mem[addr] <= data_write;
        data_read <= mem[addr];
    end

    always @(posedge clk) begin
        if (w_strobe) begin
            wq_a.push_back(addr);
            wq_d.push_back(data_write);
            chk("strobe_needs_gnt", {31'd0, bus_gnt}, 32'd1);
        end
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (err) err_cnt++;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        xs       = xs ^ b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic hdr(input logic [7:0] cmd, input logic [8:0] a, input logic [7:0] n);
        send(cmd);
        xs = 8'h00;
        send({7'd0, a[8]});
        send(a[7:0]);
        send(n);
    endtask

    task automatic trailer();
`ifdef BUS_LOADER_CHECKSUM_EN
        send(xs);
`endif
    endtask

    task automatic wait_tx(input int n, output bit req_drop);
        req_drop = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (txq.size() >= n) break;
            if (!bus_req) req_drop = 1'b1;
        end
        chk("tx_count", txq.size(), n);
    endtask

    task automatic wait_wr(input int n);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wq_a.size() >= n) break;
        end
        chk("wr_count", wq_a.size(), n);
    endtask

    task automatic pop_tx(input string tag, input logic [7:0] exp);
        if (txq.size() != 0) chk(tag, {24'd0, txq.pop_front()}, {24'd0, exp});
    endtask

    task automatic pop_wr(input string tag, input logic [8:0] ea, input logic [15:0] ed);
        if (wq_a.size() != 0) begin
            chk({tag, "_addr"}, {23'd0, wq_a.pop_front()}, {23'd0, ea});
            chk({tag, "_data"}, {16'd0, wq_d.pop_front()}, {16'd0, ed});
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
        chk({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
        chk({tag, "_w_strobe"}, {31'd0, w_strobe}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_addr"}, {23'd0, addr}, 32'd0);
        chk({tag, "_data_write"}, {16'd0, data_write}, 32'd0);
        chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    endtask

    initial begin
        bit drop;
        int e0;
        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        bus_gnt  = 1'b1;
        poke     = 1'b0;
        poke_addr = '0;
        poke_data = '0;
        xs       = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b1;

        // Non-command byte is ignored.
        send(8'h41);
        @(negedge clk);
        chk("idle_ignore_req", {31'd0, bus_req}, 32'd0);

        // Basic write of two words at 0x000.
        hdr(CMD_WRITE, 9'h000, 8'd2);
        chk("w_req_held", {31'd0, bus_req}, 32'd1);
        send(8'h34); send(8'h12); send(8'h78); send(8'h56);
        trailer();
        wait_wr(2);
        pop_wr("w0", 9'h000, 16'h1234);
        pop_wr("w1", 9'h001, 16'h5678);
        wait_tx(1, drop);
        pop_tx("w_ack", 8'h06);
        @(negedge clk);
        chk("w_req_drop", {31'd0, bus_req}, 32'd0);

        // Read one word from 0x100.
        @(negedge clk);
        poke = 1'b1; poke_addr = 9'h100; poke_data = 16'hBEEF;
        @(negedge clk);
        poke = 1'b0;
        hdr(CMD_READ, 9'h100, 8'd1);
        wait_tx(2, drop);
        chk("r_req_held", {31'd0, drop}, 32'd0);
        pop_tx("r_lo", 8'hEF);
        pop_tx("r_hi", 8'hBE);
        @(negedge clk);
        chk("r_req_drop", {31'd0, bus_req}, 32'd0);

        // Address wrap 0x1FF -> 0x000.
        hdr(CMD_WRITE, 9'h1FF, 8'd2);
        send(8'hAA); send(8'h55); send(8'hCC); send(8'h33);
        trailer();
        wait_wr(2);
        pop_wr("wrap0", 9'h1FF, 16'h55AA);
        pop_wr("wrap1", 9'h000, 16'h33CC);
        wait_tx(1, drop);
        pop_tx("wrap_ack", 8'h06);

        // Grant withheld at WR; next byte parks in the skid.
        e0 = err_cnt;
        bus_gnt = 1'b0;
        hdr(CMD_WRITE, 9'h010, 8'd2);
        send(8'h11); send(8'h22);
        repeat (50) @(negedge clk);
        chk("stall_no_strobe", wq_a.size(), 0);
        chk("stall_req", {31'd0, bus_req}, 32'd1);
        send(8'h33);
        repeat (5) @(negedge clk);
        chk("stall_skid_no_strobe", wq_a.size(), 0);
        bus_gnt = 1'b1;
        send(8'h44);
        trailer();
        wait_wr(2);
        pop_wr("stall0", 9'h010, 16'h2211);
        pop_wr("stall1", 9'h011, 16'h4433);
        wait_tx(1, drop);
        pop_tx("stall_ack", 8'h06);
        chk("stall_no_err", err_cnt - e0, 0);

        // Inter-byte timeout after ADDR_LO.
        e0 = err_cnt;
        send(CMD_WRITE); send(8'h00); send(8'h05);
        repeat (TMO + 20) @(negedge clk);
        chk("tmo_err_pulses", err_cnt - e0, 1);
        chk("tmo_req", {31'd0, bus_req}, 32'd0);
        chk("tmo_no_write", wq_a.size(), 0);
        hdr(CMD_WRITE, 9'h005, 8'd1);
        send(8'hCD); send(8'hAB);
        trailer();
        wait_wr(1);
        pop_wr("post_tmo", 9'h005, 16'hABCD);
        wait_tx(1, drop);
        pop_tx("post_tmo_ack", 8'h06);

`ifdef BUS_LOADER_CHECKSUM_EN
        // Corrupted checksum: write stays, NAK plus err.
        e0 = err_cnt;
        hdr(CMD_WRITE, 9'h020, 8'd1);
        send(8'h01); send(8'h02);
        send(xs ^ 8'hFF);
        wait_wr(1);
        pop_wr("bad_csum", 9'h020, 16'h0201);
        wait_tx(1, drop);
        pop_tx("bad_csum_nak", 8'h15);
        chk("bad_csum_err", err_cnt - e0, 1);

        // Async reset mid-payload.
        hdr(CMD_WRITE, 9'h030, 8'd2);
        send(8'h10);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("midreset_no_write", wq_a.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
